// File: rtl/uart_tx_unit_if.sv
// uart_tx_unit_if: host-side request and serial-line status bundle
// master drives send/data/config, slave returns line and flags
interface uart_tx_unit_if;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output send, data_in, parity_type, baud_rate,
    input  data_tx, active_flag, done_flag
  );

  modport slave (
    input  send, data_in, parity_type, baud_rate,
    output data_tx, active_flag, done_flag
  );
endinterface

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: start/8 data/optional parity/stop UART serialiser
// ports: clock, reset_n (async low), bus (slave: request in, line out)
module uart_tx_unit #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_unit_if.slave  bus
);
  localparam int D0 = CLK_FREQ / 2400;
  localparam int D1 = CLK_FREQ / 4800;
  localparam int D2 = CLK_FREQ / 9600;
  localparam int D3 = CLK_FREQ / 19200;
  localparam int CW = $clog2(D0 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par_en;
  logic          r_par_bit;
  logic          r_tx;
  logic          r_active;
  logic          r_done;

  logic [CW-1:0] w_div;
  logic          w_end;
  logic          w_par_en;
  logic          w_par;

  always_comb begin
    w_div = CW'(D0);
    case (bus.baud_rate)
      2'b00:   w_div = CW'(D0);
      2'b01:   w_div = CW'(D1);
      2'b10:   w_div = CW'(D2);
      default: w_div = CW'(D3);
    endcase
  end

  assign w_end    = (r_cnt == r_div - CW'(1));
  assign w_par_en = (bus.parity_type == 2'b01)
                  | (bus.parity_type == 2'b10);
  // odd: data ones + parity is odd; even: that total is even
  assign w_par    = (bus.parity_type == 2'b01)
                  ? ~^bus.data_in : ^bus.data_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx     <= 1'b1;
          r_active <= 1'b0;
          if (bus.send) begin
            r_shift   <= bus.data_in;
            r_div     <= w_div;
            r_par_en  <= w_par_en;
            r_par_bit <= w_par;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= 1'b0;
            r_active  <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_end) begin
            r_cnt    <= '0;
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt    <= '0;
          r_tx     <= 1'b1;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_tx     = r_tx;
  assign bus.active_flag = r_active;
  assign bus.done_flag   = r_done;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: table, hand-written and random frames vs a model
// small CLK_FREQ keeps divisors at 83/41/20/10 clocks
module tb_uart_tx_unit;
  localparam int CF = 200000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clock = ~clock;

  uart_tx_unit_if bus ();

  uart_tx_unit #(.CLK_FREQ(CF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] pt;
    logic [1:0] br;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic int divof(input logic [1:0] b);
    return CF / (2400 << b);
  endfunction

  // frame bits in line order; n is 10 or 11
  function automatic void model(input logic [7:0] d,
                                input logic [1:0] pt,
                                output logic [10:0] bits,
                                output int n);
    int ones;
    ones = $countones(d);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pt == 2'b01) begin
      bits[9] = (ones % 2 == 0);
      n = 11;
    end else if (pt == 2'b10) begin
      bits[9] = (ones % 2 == 1);
      n = 11;
    end else begin
      n = 10;
    end
  endfunction

  task automatic run_frame(input logic [7:0] d, input logic [1:0] pt,
                           input logic [1:0] br, input bit disturb,
                           output int alen, output logic pbit);
    logic [10:0] bits;
    int n, dv, tot;
    logic etx, eact, edone;
    model(d, pt, bits, n);
    dv = divof(br);
    tot = n * dv;
    alen = 0;
    pbit = 1'b0;
    @(negedge clock);
    bus.send = 1'b1;
    bus.data_in = d;
    bus.parity_type = pt;
    bus.baud_rate = br;
    for (int k = 0; k <= tot + 3; k++) begin
      @(negedge clock);
      if (k == 0) bus.send = 1'b0;
      if (disturb && k == tot / 2) begin
        bus.send = 1'b1;
        bus.data_in = 8'hFF;
        bus.parity_type = ~pt;
        bus.baud_rate = ~br;
      end
      if (disturb && k == tot / 2 + 1) bus.send = 1'b0;
      if (k < tot) begin
        etx = bits[k/dv]; eact = 1'b1; edone = 1'b0;
      end else begin
        etx = 1'b1; eact = 1'b0; edone = (k == tot);
      end
      if (bus.active_flag === 1'b1) alen++;
      if (k == 9 * dv + dv / 2) pbit = bus.data_tx;
      chk($sformatf("data_tx@%0d", k), {31'b0, bus.data_tx}, {31'b0, etx});
      chk($sformatf("active@%0d", k), {31'b0, bus.active_flag},
          {31'b0, eact});
      chk($sformatf("done@%0d", k), {31'b0, bus.done_flag},
          {31'b0, edone});
    end
  endtask

  vec_t tbl[7];
  int   alen;
  logic pbit;

  initial begin
    logic [10:0] bits;
    int n, dv, L, cnt, dones, bound;
    logic etx, eact, edone;
    int lows[4];

    tbl[0] = '{8'h35, 2'b10, 2'b11, 110, 1'b0};
    tbl[1] = '{8'h35, 2'b01, 2'b10, 220, 1'b1};
    tbl[2] = '{8'hA5, 2'b00, 2'b00, 830, 1'b1};
    tbl[3] = '{8'hA5, 2'b11, 2'b00, 830, 1'b1};
    tbl[4] = '{8'hFF, 2'b01, 2'b11, 110, 1'b1};
    tbl[5] = '{8'h80, 2'b10, 2'b01, 451, 1'b1};
    tbl[6] = '{8'h00, 2'b10, 2'b11, 110, 1'b0};
    lows = '{747, 369, 180, 90};

    bus.send = 1'b0;
    bus.data_in = 8'h00;
    bus.parity_type = 2'b00;
    bus.baud_rate = 2'b00;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'b0, bus.data_tx}, 32'd1);
    chk("rst_act", {31'b0, bus.active_flag}, 32'd0);
    chk("rst_done", {31'b0, bus.done_flag}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_tx", {31'b0, bus.data_tx}, 32'd1);
    chk("idle_act", {31'b0, bus.active_flag}, 32'd0);

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].d, tbl[i].pt, tbl[i].br, 1'b0, alen, pbit);
      chk($sformatf("len[%0d]", i), alen, tbl[i].exp_len);
      chk($sformatf("par_slot[%0d]", i), {31'b0, pbit},
          {31'b0, tbl[i].exp_par});
    end

    // send and new data mid-frame are ignored
    run_frame(8'h35, 2'b10, 2'b11, 1'b1, alen, pbit);
    chk("disturb_len", alen, 110);

    // send held high: two frames with a one-clock gap
    model(8'h5C, 2'b01, bits, n);
    dv = divof(2'b11);
    L = n * dv + 1;
    dones = 0;
    @(negedge clock);
    bus.send = 1'b1;
    bus.data_in = 8'h5C;
    bus.parity_type = 2'b01;
    bus.baud_rate = 2'b11;
    for (int k = 0; k <= 2 * L + 2; k++) begin
      @(negedge clock);
      if (k == L) bus.send = 1'b0;
      if (k >= 2 * L) begin
        etx = 1'b1; eact = 1'b0; edone = (k == 2 * L - 1);
      end else if (k % L < n * dv) begin
        etx = bits[(k % L) / dv]; eact = 1'b1; edone = 1'b0;
      end else begin
        etx = 1'b1; eact = 1'b0; edone = 1'b1;
      end
      if (bus.done_flag === 1'b1) dones++;
      chk($sformatf("b2b_tx@%0d", k), {31'b0, bus.data_tx}, {31'b0, etx});
      chk($sformatf("b2b_act@%0d", k), {31'b0, bus.active_flag},
          {31'b0, eact});
      chk($sformatf("b2b_done@%0d", k), {31'b0, bus.done_flag},
          {31'b0, edone});
    end
    chk("b2b_dones", dones, 2);

    // async reset during data bit 3
    @(negedge clock);
    bus.send = 1'b1;
    bus.data_in = 8'hF0;
    bus.parity_type = 2'b10;
    bus.baud_rate = 2'b11;
    @(negedge clock);
    bus.send = 1'b0;
    repeat (4 * 10 + 2) @(negedge clock);
    chk("pre_rst_act", {31'b0, bus.active_flag}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx", {31'b0, bus.data_tx}, 32'd1);
    chk("arst_act", {31'b0, bus.active_flag}, 32'd0);
    chk("arst_done", {31'b0, bus.done_flag}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.active_flag !== 1'b0 || bus.data_tx !== 1'b1
          || bus.done_flag !== 1'b0) cnt++;
    end
    chk("post_rst_idle_bad", cnt, 0);
    run_frame(8'h35, 2'b10, 2'b11, 1'b0, alen, pbit);
    chk("post_rst_len", alen, 110);

    // baud sweep: low time of start + 8 zero bits
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      bus.send = 1'b1;
      bus.data_in = 8'h00;
      bus.parity_type = 2'b00;
      bus.baud_rate = 2'(b);
      @(negedge clock);
      bus.send = 1'b0;
      cnt = 0;
      bound = 0;
      while (bus.data_tx === 1'b0 && bound < 2000) begin
        cnt++;
        bound++;
        @(negedge clock);
      end
      chk($sformatf("low_time[%0d]", b), cnt, lows[b]);
      bound = 0;
      while (bus.active_flag !== 1'b0 && bound < 200) begin
        bound++;
        @(negedge clock);
      end
      chk($sformatf("sweep_end[%0d]", b), {31'b0, bus.active_flag}, 32'd0);
    end

    // random frames against the model
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic [1:0] pt, br;
      d = 8'($urandom);
      pt = 2'($urandom_range(0, 3));
      br = 2'($urandom_range(0, 3));
      model(d, pt, bits, n);
      run_frame(d, pt, br, 1'($urandom_range(0, 1)), alen, pbit);
      chk($sformatf("rnd_len[%0d]", i), alen, n * divof(br));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
